// File: rtl/nes_mem_pkg.sv
// Shared CPU-bus definitions for the memory subsystem: register addresses, DMA state encoding, bus bundle.
// No logic; constants, types and one helper only.
package nes_mem_pkg;

  localparam logic [15:0] ADDR_PPU_OAMADDR = 16'h2003;
  localparam logic [15:0] ADDR_PPU_OAMDATA = 16'h2004;
  localparam logic [15:0] ADDR_OAM_DMA     = 16'h4014;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_READ  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        write_en;
    logic        read_en;
  } bus_t;

  function automatic logic is_dma_trigger(input bus_t b);
    return b.write_en && (b.addr == ADDR_OAM_DMA);
  endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Selects core-driven or DMA-driven CPU bus cycle; purely combinational, zero latency.
// No backpressure of its own: the DMA side wins whenever sel_dma is high.
module oam_dma_bus_mux
  import nes_mem_pkg::*;
(
  input  logic sel_dma,
  input  bus_t core_bus,
  input  bus_t dma_bus,
  output bus_t bus
);

  assign bus = sel_dma ? dma_bus : core_bus;

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA initiator: a write to $4014 copies page $PP00-$PPFF into OAM via $2004 (OAM_DMA_ALIGN_EN adds get/put alignment).
// Latency 2+RD_LATENCY cycles per byte; the core is stalled and its strobes dropped for the whole transfer.
module oam_dma_ctrl
  import nes_mem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int DMA_BYTES  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_data,
  input  logic        core_write_en,
  input  logic        core_read_en,
  input  logic [7:0]  mem_data_out,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data,
  output logic        bus_write_en,
  output logic        bus_read_en,
  output logic        core_stall,
  output logic        dma_busy
);

  localparam logic [7:0] LAST_IDX  = 8'(DMA_BYTES - 1);
  localparam logic [1:0] HOLD_LAST = 2'(RD_LATENCY);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [1:0]  hcnt;
  logic [7:0]  byte_q;
  logic        busy_q;
  logic [15:0] dma_addr_q;
  logic        dma_re_q;
  logic        dma_we_q;

  bus_t core_bus;
  bus_t dma_bus;
  bus_t mux_bus;

  assign core_bus = '{addr: core_addr, data: core_data,
                      write_en: core_write_en, read_en: core_read_en};
  assign dma_bus  = '{addr: dma_addr_q, data: byte_q,
                      write_en: dma_we_q, read_en: dma_re_q};

`ifdef OAM_DMA_ALIGN_EN
  logic cyc_odd;

  always_ff @(posedge clk) begin
    if (rst) cyc_odd <= 1'b0;
    else     cyc_odd <= ~cyc_odd;
  end
`endif

  // Bus-side outputs are registered alongside the state so they change only on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      hcnt       <= 2'd0;
      byte_q     <= 8'h00;
      busy_q     <= 1'b0;
      dma_addr_q <= 16'h0000;
      dma_re_q   <= 1'b0;
      dma_we_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_dma_trigger(core_bus)) begin
            page   <= core_data;
            idx    <= 8'h00;
            hcnt   <= 2'd0;
            busy_q <= 1'b1;
`ifdef OAM_DMA_ALIGN_EN
            state      <= ST_ALIGN;
            dma_re_q   <= 1'b0;
            dma_we_q   <= 1'b0;
`else
            state      <= ST_READ;
            dma_addr_q <= {core_data, 8'h00};
            dma_re_q   <= 1'b1;
            dma_we_q   <= 1'b0;
`endif
          end
        end
`ifdef OAM_DMA_ALIGN_EN
        ST_ALIGN: begin
          // hcnt[0] marks the extra dummy cycle taken when alignment lands on an odd cycle.
          if (cyc_odd && !hcnt[0]) begin
            hcnt <= 2'd1;
          end else begin
            state      <= ST_READ;
            dma_addr_q <= {page, idx};
            dma_re_q   <= 1'b1;
          end
        end
`endif
        ST_READ: begin
          state    <= ST_HOLD;
          hcnt     <= 2'd1;
          dma_re_q <= 1'b0;
        end
        ST_HOLD: begin
          if (hcnt < HOLD_LAST) begin
            hcnt <= hcnt + 2'd1;
          end else begin
            byte_q     <= mem_data_out;
            state      <= ST_WRITE;
            dma_addr_q <= ADDR_PPU_OAMDATA;
            dma_we_q   <= 1'b1;
          end
        end
        ST_WRITE: begin
          dma_we_q <= 1'b0;
          if (idx == LAST_IDX) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            idx        <= idx + 8'd1;
            state      <= ST_READ;
            dma_addr_q <= {page, idx + 8'd1};
            dma_re_q   <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_q   <= 1'b0;
          dma_re_q <= 1'b0;
          dma_we_q <= 1'b0;
        end
      endcase
    end
  end

  oam_dma_bus_mux u_mux (
    .sel_dma  (busy_q),
    .core_bus (core_bus),
    .dma_bus  (dma_bus),
    .bus      (mux_bus)
  );

  assign bus_addr     = mux_bus.addr;
  assign bus_data     = mux_bus.data;
  assign bus_write_en = mux_bus.write_en;
  assign bus_read_en  = mux_bus.read_en;
  assign core_stall   = busy_q;
  assign dma_busy     = busy_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: behavioural CPU memory/OAM model on the bus plus a per-cycle transfer-timeline model.
// Honours OAM_DMA_ALIGN_EN for the alignment cases.
module tb_oam_dma_ctrl;

  localparam int L  = 1;
  localparam int N  = 256;
  localparam int BC = 2 + L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] core_addr = 16'h0000;
  logic [7:0]  core_data = 8'h00;
  logic        core_write_en = 1'b0;
  logic        core_read_en = 1'b0;
  logic [7:0]  mem_data_out = 8'h00;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_write_en;
  logic        bus_read_en;
  logic        core_stall;
  logic        dma_busy;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.RD_LATENCY(L), .DMA_BYTES(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_addr     (core_addr),
    .core_data     (core_data),
    .core_write_en (core_write_en),
    .core_read_en  (core_read_en),
    .mem_data_out  (mem_data_out),
    .bus_addr      (bus_addr),
    .bus_data      (bus_data),
    .bus_write_en  (bus_write_en),
    .bus_read_en   (bus_read_en),
    .core_stall    (core_stall),
    .dma_busy      (dma_busy)
  );

  // mem_ctrl stand-in: registered read data, $2003/$2004 OAM port, writes ignored while in reset.
  logic [7:0] mem   [0:65535];
  logic [7:0] spram [0:255];
  logic [7:0] oam_addr = 8'h00;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus_read_en) mem_data_out <= mem[bus_addr];
      if (bus_write_en) begin
        if (bus_addr == 16'h2003) oam_addr <= bus_data;
        else if (bus_addr == 16'h2004) begin
          spram[oam_addr] <= bus_data;
          oam_addr <= oam_addr + 8'd1;
        end else mem[bus_addr] <= bus_data;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_write_en = 1'b0;
    core_read_en  = 1'b0;
    core_addr     = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    core_addr = a;
    core_data = d;
    core_write_en = 1'b1;
    core_read_en  = 1'b0;
    cyc();
    idle();
  endtask

  // Trigger a transfer and ride it out while throwing random core strobes at the block.
  task automatic run_dma(input logic [7:0] pg, output int n, output int last_rd, output int saw0);
    wr(16'h4014, pg);
    n = 0; last_rd = -1; saw0 = 0;
    while (core_stall && n < 4000) begin
      n++;
      if (bus_read_en) last_rd = int'(bus_addr);
      if ((bus_read_en || bus_write_en) && bus_addr == 16'h0000) saw0 = 1;
      core_addr     = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
      core_data     = 8'($urandom);
      core_write_en = 1'($urandom_range(0, 1));
      core_read_en  = 1'($urandom_range(0, 1));
      cyc();
    end
    idle();
    if (n >= 4000) chk("dma_timeout", n, 0);
  endtask

  // Transfer timeline model: byte b, phase ph within each 2+L slot after any alignment cycles.
  bit         m_busy = 1'b0;
  int         m_t = 0;
  int         m_align = 0;
  logic [7:0] m_page = 8'h00;
`ifdef OAM_DMA_ALIGN_EN
  bit         par = 1'b0;
  bit         npar;
`endif

  task automatic compare_loop();
    int tt, b, ph;
    logic [15:0] ea;
    forever begin
      @(negedge clk);
      if (!m_busy) begin
        chk("pass_addr", int'(bus_addr), int'(core_addr));
        chk("pass_data", int'(bus_data), int'(core_data));
        chk("pass_we", int'(bus_write_en), int'(core_write_en));
        chk("pass_re", int'(bus_read_en), int'(core_read_en));
        chk("idle_stall", int'(core_stall), 0);
        chk("idle_busy", int'(dma_busy), 0);
      end else begin
        chk("dma_stall", int'(core_stall), 1);
        chk("dma_busy", int'(dma_busy), 1);
        tt = m_t - m_align;
        if (tt < 0) begin
          chk("align_re", int'(bus_read_en), 0);
          chk("align_we", int'(bus_write_en), 0);
        end else begin
          b  = tt / BC;
          ph = tt % BC;
          ea = {m_page, 8'(b)};
          if (ph == 0) begin
            chk("rd_addr", int'(bus_addr), int'(ea));
            chk("rd_re", int'(bus_read_en), 1);
            chk("rd_we", int'(bus_write_en), 0);
          end else if (ph <= L) begin
            chk("hold_addr", int'(bus_addr), int'(ea));
            chk("hold_re", int'(bus_read_en), 0);
            chk("hold_we", int'(bus_write_en), 0);
          end else begin
            chk("wr_addr", int'(bus_addr), 16'h2004);
            chk("wr_data", int'(bus_data), int'(mem[ea]));
            chk("wr_we", int'(bus_write_en), 1);
            chk("wr_re", int'(bus_read_en), 0);
          end
        end
      end
`ifdef OAM_DMA_ALIGN_EN
      npar = rst ? 1'b0 : !par;
`endif
      if (rst) m_busy = 1'b0;
      else if (!m_busy) begin
        if (core_write_en && core_addr == 16'h4014) begin
          m_busy = 1'b1; m_t = 0; m_page = core_data; m_align = 0;
`ifdef OAM_DMA_ALIGN_EN
          m_align = npar ? 2 : 1;
`endif
        end
      end else begin
        m_t++;
        if (m_t == m_align + N * BC) m_busy = 1'b0;
      end
`ifdef OAM_DMA_ALIGN_EN
      par = npar;
`endif
    end
  endtask

  logic [7:0] exp3 [0:255];
  int n, lr, s0, w, n1;
  bit hit, seen769, seen770;

  initial begin
    core_addr = 16'h1234;
    core_data = 8'h77;
    cyc();
    chk("rst_stall", int'(core_stall), 0);
    chk("rst_busy", int'(dma_busy), 0);
    chk("rst_pass_addr", int'(bus_addr), 16'h1234);
    chk("rst_pass_data", int'(bus_data), 8'h77);
    cyc(); cyc();
    rst = 1'b0;
    idle();
    fork compare_loop(); join_none

    // 1: page $02 into OAM from index 0.
    for (int i = 0; i < 256; i++) wr(16'h0200 + 16'(i), 8'(i) ^ 8'h5A);
    wr(16'h2003, 8'h00);
    run_dma(8'h02, n, lr, s0);
`ifdef OAM_DMA_ALIGN_EN
    chk("t1_stall_range", int'(n == 769 || n == 770), 1);
`else
    chk("t1_stall", n, 768);
`endif
    for (int i = 0; i < 256; i++) chk("t1_spram", int'(spram[i]), int'(8'(i) ^ 8'h5A));

    // 2: OAM start at $F0 wraps through $00..$EF.
    for (int i = 0; i < 256; i++) begin
      exp3[i] = 8'($urandom);
      wr(16'h0300 + 16'(i), exp3[i]);
    end
    wr(16'h2003, 8'hF0);
    run_dma(8'h03, n, lr, s0);
    for (int i = 0; i < 256; i++) chk("t2_spram", int'(spram[8'(8'hF0 + 8'(i))]), int'(exp3[i]));
    chk("t2_lit_00", int'(spram[0]), int'(exp3[16]));

    // 3: page $FF never carries into $0000.
    for (int i = 0; i < 256; i++) wr(16'hFF00 + 16'(i), 8'(i) ^ 8'hA5);
    run_dma(8'hFF, n, lr, s0);
    chk("t3_last_read", lr, 16'hFFFF);
    chk("t3_no_zero", s0, 0);
    chk("t3_idle_after", int'(dma_busy), 0);
    chk("t3_last_byte", int'(spram[8'hEF]), 8'h5A);

    // 4: reset lands during the $2004 write of index 100.
    wr(16'h2003, 8'h00);
    for (int i = 0; i < 256; i++) wr(16'h2004, 8'(i) ^ 8'hC3);
    wr(16'h2003, 8'h00);
    wr(16'h4014, 8'h02);
    w = 0; n = 0; hit = 1'b0;
    while (core_stall && n < 4000 && !hit) begin
      if (bus_write_en && bus_addr == 16'h2004) begin
        if (w == 100) hit = 1'b1;
        w++;
      end
      if (!hit) begin
        cyc();
        n++;
      end
    end
    chk("t4_reached", int'(hit), 1);
`ifndef OAM_DMA_ALIGN_EN
    chk("t4_cycle", n, 302);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t4_busy", int'(dma_busy), 0);
    chk("t4_stall", int'(core_stall), 0);
    for (int i = 0; i < 100; i++) chk("t4_written", int'(spram[i]), int'(8'(i) ^ 8'h5A));
    chk("t4_untouched100", int'(spram[100]), int'(8'd100 ^ 8'hC3));
    chk("t4_untouched101", int'(spram[101]), int'(8'd101 ^ 8'hC3));

    // 5: ordinary PPU register traffic passes straight through.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       begin core_addr = 16'h2002; core_read_en = 1'b1; core_write_en = 1'b0; end
        1:       begin core_addr = 16'h2006; core_read_en = 1'b0; core_write_en = 1'b1; end
        default: begin core_addr = 16'h2007; core_read_en = 1'b0; core_write_en = 1'b1; end
      endcase
      core_data = 8'($urandom);
      #1;
      chk("t5_stall", int'(core_stall), 0);
      cyc();
    end
    idle();

`ifdef OAM_DMA_ALIGN_EN
    // 6: both alignment parities must be seen.
    seen769 = 1'b0; seen770 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 1) cyc();
      run_dma(8'h02, n1, lr, s0);
      chk("t6_stall_range", int'(n1 == 769 || n1 == 770), 1);
      if (n1 == 769) seen769 = 1'b1;
      if (n1 == 770) seen770 = 1'b1;
    end
    chk("t6_both_parities", int'(seen769 && seen770), 1);
`endif

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
